mmio_button_input: RTL and testbench

- Input-direction counterpart to the board's output path (LEDs, 7-segment): conditions raw active-low devboard buttons into a clean 32-bit MMIO input word for the core.
- Per button: synchronizes, debounces, and latches sticky press/release event flags that the core clears via an MMIO write strobe.
- Sits between the board pins and a core MMIO input slot; removes unsynchronized raw buttons from the core boundary.

---
 rtl/mmio_button_input_pkg.sv | 22 ++
 rtl/mmio_button_input_debounce_channel.sv | 115 +++++++++++
 rtl/mmio_button_input.sv | 69 ++++++
 tb/tb_mmio_button_input.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mmio_button_input_pkg.sv
// mmio_button_pkg: shared types and field layout for the button MMIO input path.
//   debounce_state_t : per-channel debounce FSM states
//   *_FIELD          : field index inside mmioWord; bit offset = FIELD*NUM_BUTTONS
package mmio_button_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PEND_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    PEND_RELEASE = 2'd3
  } debounce_state_t;

  localparam int STATE_FIELD   = 0;
  localparam int PRESS_FIELD   = 1;
  localparam int RELEASE_FIELD = 2;
  localparam int NUM_FIELDS    = 3;

  function automatic int field_ofs(input int field, input int nbtn);
    return field * nbtn;
  endfunction

endpackage

// File: rtl/mmio_button_input_debounce_channel.sv
// debounce_channel: one button channel -- synchronizer, debounce FSM with
// stable-cycle counter, and sticky press/release event flags.
//   clk_i, rst_ni : clock, async active-low reset
//   btn_ni        : raw active-low button pin (asynchronous)
//   clr_i         : clear both event flags this edge (a same-edge set wins)
//   state_o       : debounced level, 1 = pressed
//   press_o       : sticky press-committed flag
//   release_o     : sticky release-committed flag
module debounce_channel
  import mmio_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  input  logic clr_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Reset to all ones: an idle active-low pin reads as released.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_ni};
  end

  assign p = ~sync_q[SYNC_STAGES-1];

  debounce_state_t state_q;
  logic [CW-1:0]   cnt_q;
  logic            level_q, press_q, release_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // Clear first; a commit below on the same edge overrides it.
      if (clr_i) begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end
      case (state_q)
        RELEASED: if (p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            state_q <= PEND_PRESS;
            cnt_q   <= ONE;
          end
        end
        PEND_PRESS: begin
          if (!p) begin
            state_q <= RELEASED;  // glitch discarded, no flag
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        PRESSED: if (!p) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_q   <= RELEASED;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            state_q <= PEND_RELEASE;
            cnt_q   <= ONE;
          end
        end
        PEND_RELEASE: begin
          if (p) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/mmio_button_input.sv
// mmio_button_input: conditions raw active-low buttons into a 32-bit MMIO
// input word with debounced levels and sticky press/release flags.
//   clock, notReset : clock, async active-low reset
//   notButton       : raw active-low button pins
//   clearWrite      : one-cycle strobe clearing flags chosen by clearMask
//   clearMask       : bit i clears pressFlag[i] and releaseFlag[i]
//   buttonState     : debounced levels (1 = pressed)
//   pressFlag       : sticky press events
//   releaseFlag     : sticky release events
//   mmioWord        : {0, releaseFlag, pressFlag, buttonState}
module mmio_button_input
  import mmio_button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                   clock,
  input  logic                   notReset,
  input  logic [NUM_BUTTONS-1:0] notButton,
  input  logic                   clearWrite,
  input  logic [NUM_BUTTONS-1:0] clearMask,
  output logic [NUM_BUTTONS-1:0] buttonState,
  output logic [NUM_BUTTONS-1:0] pressFlag,
  output logic [NUM_BUTTONS-1:0] releaseFlag,
  output logic [31:0]            mmioWord
);

  if (NUM_FIELDS * NUM_BUTTONS > 32 || NUM_BUTTONS < 1) begin : g_bad_nbtn
    $error("mmio_button_input: NUM_BUTTONS must satisfy 1 <= 3*NUM_BUTTONS <= 32");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("mmio_button_input: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("mmio_button_input: SYNC_STAGES must be >= 2");
  end

  localparam int ST_OFS  = field_ofs(STATE_FIELD,   NUM_BUTTONS);
  localparam int PR_OFS  = field_ofs(PRESS_FIELD,   NUM_BUTTONS);
  localparam int RL_OFS  = field_ofs(RELEASE_FIELD, NUM_BUTTONS);

  logic [NUM_BUTTONS-1:0] clr;
  assign clr = clearWrite ? clearMask : '0;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_ch (
      .clk_i     (clock),
      .rst_ni    (notReset),
      .btn_ni    (notButton[i]),
      .clr_i     (clr[i]),
      .state_o   (buttonState[i]),
      .press_o   (pressFlag[i]),
      .release_o (releaseFlag[i])
    );
  end

  // Pure pack of registered outputs; no added latency.
  always_comb begin
    mmioWord = '0;
    mmioWord[ST_OFS +: NUM_BUTTONS] = buttonState;
    mmioWord[PR_OFS +: NUM_BUTTONS] = pressFlag;
    mmioWord[RL_OFS +: NUM_BUTTONS] = releaseFlag;
  end

endmodule

// File: tb/tb_mmio_button_input.sv
module tb_mmio_button_input;

  logic        clock = 1'b0;
  logic        notReset;
  logic [3:0]  notButton;
  logic        clearWrite;
  logic [3:0]  clearMask;
  logic [3:0]  buttonState, pressFlag, releaseFlag;
  logic [31:0] mmioWord;

  int vectors = 0;
  int errs    = 0;

  mmio_button_input #(
    .NUM_BUTTONS     (4),
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clock       (clock),
    .notReset    (notReset),
    .notButton   (notButton),
    .clearWrite  (clearWrite),
    .clearMask   (clearMask),
    .buttonState (buttonState),
    .pressFlag   (pressFlag),
    .releaseFlag (releaseFlag),
    .mmioWord    (mmioWord)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one so
  // checks sample away from the edge and new inputs land between edges.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    notReset   = 1'b1;
    notButton  = 4'hF;
    clearWrite = 1'b0;
    clearMask  = 4'h0;
    #1 notReset = 1'b0;
    #2;
    chk("reset_mmio", mmioWord, 32'h0);
    chk("reset_fields", {20'h0, releaseFlag, pressFlag, buttonState}, 32'h0);
    step(3);
    chk("reset_held", mmioWord, 32'h0);
    notReset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk($sformatf("idle_%0d", c), mmioWord, 32'h0);
    end

    // Clean press/release on button 0: commit at edge 6
    notButton = 4'b1110;
    step(5);
    chk("press0_edge5", mmioWord, 32'h0);
    step(1);
    chk("press0_edge6", mmioWord, 32'h011);
    notButton = 4'hF;
    step(5);
    chk("rel0_edge5", mmioWord, 32'h011);
    step(1);
    chk("rel0_edge6", mmioWord, 32'h110);

    // Glitch on button 2 for 3 cycles: nothing committed
    notButton = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      step(1);
      chk($sformatf("glitch_hi_%0d", c), {29'h0, releaseFlag[2], pressFlag[2], buttonState[2]}, 32'h0);
    end
    notButton = 4'hF;
    for (int c = 0; c < 8; c++) begin
      step(1);
      chk($sformatf("glitch_lo_%0d", c), {29'h0, releaseFlag[2], pressFlag[2], buttonState[2]}, 32'h0);
    end
    chk("glitch_mmio", mmioWord, 32'h110);

    // Button 1 press, then clear its press flag
    notButton = 4'b1101;
    step(6);
    chk("press1", mmioWord, 32'h132);
    clearWrite = 1'b1; clearMask = 4'b0010;
    step(1);
    clearWrite = 1'b0; clearMask = 4'b0000;
    chk("clear1", mmioWord, 32'h112);

    // Release button 1, then re-press with clear on the commit edge
    notButton = 4'hF;
    step(6);
    chk("rel1", mmioWord, 32'h310);
    notButton = 4'b1101;
    step(5);
    clearWrite = 1'b1; clearMask = 4'b0010;
    step(1);
    clearWrite = 1'b0;
    chk("collide_setwins", mmioWord, 32'h132);

    // Mask without strobe is ignored
    clearMask = 4'hF;
    step(2);
    chk("mask_no_strobe", mmioWord, 32'h132);

    notButton = 4'hF;
    step(6);
    chk("rel1_again", mmioWord, 32'h330);
    clearWrite = 1'b1;
    step(1);
    clearWrite = 1'b0; clearMask = 4'h0;
    chk("clear_all", mmioWord, 32'h0);

    // All four pressed together
    notButton = 4'h0;
    step(5);
    chk("all_edge5", mmioWord, 32'h0);
    step(1);
    chk("all_edge6", mmioWord, 32'h0FF);
    clearWrite = 1'b1; clearMask = 4'b0101;
    step(1);
    clearWrite = 1'b0; clearMask = 4'h0;
    chk("clear_0101", mmioWord, 32'h0AF);
    chk("clear_0101_pf", {28'h0, pressFlag}, 32'hA);

    notButton = 4'hF;
    step(6);
    chk("all_rel", mmioWord, 32'hFA0);
    clearWrite = 1'b1; clearMask = 4'hF;
    step(1);
    clearWrite = 1'b0; clearMask = 4'h0;
    chk("clear_all2", mmioWord, 32'h0);

    // Reset mid-debounce on button 3
    notButton = 4'b0111;
    step(3);
    @(posedge clock);
    #1 notReset = 1'b0;
    #1;
    chk("midrst_mmio", mmioWord, 32'h0);
    step(3);
    chk("midrst_held", {20'h0, releaseFlag, pressFlag, buttonState}, 32'h0);
    notReset = 1'b1;
    step(5);
    chk("midrst_edge5", mmioWord, 32'h0);
    step(1);
    chk("midrst_edge6", mmioWord, 32'h088);
    chk("midrst_pf3", {31'h0, pressFlag[3]}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
